// File: rtl/sequential_divider_pkg.sv
// Shared definitions for the sequential restoring divider: default widths,
// controller state encoding and the iteration-counter width helper.
package sequential_divider_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int VW_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter able to hold the values 0..dw.
  function automatic int count_width(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/sequential_divider_if.sv
// Start/ready/done handshake plus operand and result buses of the divider.
// The requester drives the operands; the divider drives status and results.
interface sequential_divider_if
  import sequential_divider_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int VW = VW_DEFAULT
) ();

  logic          start;
  logic [DW-1:0] a;
  logic [VW-1:0] b;
  logic          ready;
  logic          done;
  logic          div_by_zero;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;

  modport master (
    output start, a, b,
    input  ready, done, div_by_zero, quotient, remainder
  );

  modport slave (
    input  start, a, b,
    output ready, done, div_by_zero, quotient, remainder
  );

endinterface

// File: rtl/restoring_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference when it
// is non-negative. Purely combinational.
module restoring_div_step #(
  parameter int VW = 4
) (
  input  logic [VW-1:0] r,       // partial remainder, always < d
  input  logic          qmsb,    // dividend bit being brought down
  input  logic [VW-1:0] d,       // divisor
  output logic [VW-1:0] r_next,  // updated partial remainder, still < d
  output logic          qbit     // quotient bit produced by this step
);

  logic [VW:0] shifted;
  logic [VW:0] trial;

  // Since r < d, the shifted value is < 2*d and fits VW+1 bits.
  assign shifted = {r, qmsb};
  assign trial   = shifted - {1'b0, d};
  assign qbit    = ~trial[VW];

  // Whichever value is kept is < d, so its top bit is always zero.
  assign r_next  = qbit ? trial[VW-1:0] : shifted[VW-1:0];

endmodule

// File: rtl/sequential_divider.sv
// Sequential restoring divider producing one quotient bit per clock.
// IDLE accepts operands, CALC runs DW iterations, DONE pulses done for one
// cycle. A zero divisor skips CALC and reports div_by_zero.
module sequential_divider
  import sequential_divider_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int VW = VW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  sequential_divider_if.slave bus
);

  localparam int CW = count_width(DW);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] count_q;
  logic [DW-1:0] q_q;          // dividend shifting out, quotient shifting in
  logic [VW-1:0] d_q;          // captured divisor
  logic [VW-1:0] r_q;          // partial remainder (invariant r_q < d_q)
  logic [DW-1:0] quotient_q;
  logic [VW-1:0] remainder_q;
  logic          dbz_q;

  logic          accept;
  logic          last_iter;
  logic          step_qbit;
  logic [VW-1:0] step_r;
  logic          b_is_zero;

  assign b_is_zero = (bus.b == '0);

  restoring_div_step #(.VW(VW)) u_step (
    .r      (r_q),
    .qmsb   (q_q[DW-1]),
    .d      (d_q),
    .r_next (step_r),
    .qbit   (step_qbit)
  );

  // Next-state and control decode for the IDLE/CALC/DONE controller.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    state_d   = state_q;
    accept    = 1'b0;
    last_iter = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = b_is_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (count_q == CW'(DW - 1)) begin
          last_iter = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Controller state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Operand capture, per-iteration datapath update and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else if (accept) begin
      q_q     <= bus.a;
      d_q     <= bus.b;
      r_q     <= '0;
      count_q <= '0;
      dbz_q   <= b_is_zero;
      // A zero divisor goes straight to DONE, so its results load now.
      if (b_is_zero) begin
        quotient_q  <= '1;
        remainder_q <= bus.a[VW-1:0];
      end
    end else if (state_q == CALC) begin
      q_q     <= {q_q[DW-2:0], step_qbit};
      r_q     <= step_r;
      count_q <= count_q + CW'(1);
      if (last_iter) begin
        quotient_q  <= {q_q[DW-2:0], step_qbit};
        remainder_q <= step_r;
      end
    end
  end

  assign bus.ready       = (state_q == IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.div_by_zero = dbz_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider: stimulus pushes expected results
// from an arithmetic reference model; a monitor pops and compares on done.
module tb_sequential_divider;

  localparam int DW = 8;
  localparam int VW = 4;
  localparam int CALC_LAT = DW + 1;  // negedges from accept to done, b != 0

  typedef struct {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dbz;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t exp_q[$];

  sequential_divider_if #(.DW(DW), .VW(VW)) bus ();

  sequential_divider #(.DW(DW), .VW(VW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference: plain unsigned division, with the zero-divisor convention.
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q   = '1;
      e.r   = VW'(a % (1 << VW));
      e.dbz = 1'b1;
    end else begin
      e.q   = DW'(a / b);
      e.r   = VW'(a % b);
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done) begin
        check("ready_with_done", bus.ready, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("quotient", bus.quotient, e.q);
          check("remainder", bus.remainder, e.r);
          check("div_by_zero", bus.div_by_zero, e.dbz);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) check("ready_timeout", 0, 1);
  endtask

  // Presents operands for one accept edge; returns at the following negedge.
  task automatic launch(input int a, input int b, input bit expect_result);
    wait_ready();
    bus.a     = DW'(a);
    bus.b     = VW'(b);
    bus.start = 1'b1;
    if (expect_result) exp_q.push_back(model(a, b));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called at the first negedge after accept; counts negedges until done.
  task automatic wait_done(input int lat);
    int n = 1;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, lat);
  endtask

  task automatic run_op(input int a, input int b);
    launch(a, b, 1'b1);
    wait_done((b == 0) ? 1 : CALC_LAT);
  endtask

  initial begin
    int n;
    int t;
    int last_t;
    int accepts;
    int dones;
    int seen_done;
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready", bus.ready, 1);
    check("rst_done", bus.done, 0);
    check("rst_dbz", bus.div_by_zero, 0);
    check("rst_quotient", bus.quotient, 0);
    check("rst_remainder", bus.remainder, 0);
    rst = 1'b1;
    @(negedge clk);

    // Directed divisions, including extreme operands.
    run_op(200, 7);
    run_op(255, 1);
    run_op(13, 15);
    run_op(0, 5);
    run_op(255, 15);

    // Zero divisor: results hold after done, dbz clears on the next accept.
    run_op(8'h5A, 0);
    @(negedge clk);
    check("dbz_hold", bus.div_by_zero, 1);
    check("dbz_q_hold", bus.quotient, 8'hFF);
    check("dbz_r_hold", bus.remainder, 4'hA);
    launch(6, 3, 1'b1);
    check("dbz_cleared", bus.div_by_zero, 0);
    check("q_held_in_calc", bus.quotient, 8'hFF);
    wait_done(CALC_LAT);

    // start pulses during CALC and during DONE are ignored.
    launch(200, 7, 1'b1);
    n = 1;
    while (!bus.done && n < 40) begin
      if (n == 3 || n == 6) begin
        bus.a     = 8'd1;
        bus.b     = 4'd1;
        bus.start = 1'b1;
      end
      @(negedge clk);
      bus.start = 1'b0;
      n++;
    end
    check("latency_ignore", n, CALC_LAT);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (12) @(negedge clk);

    // Reset in CALC cycle 4 aborts with no done pulse.
    launch(200, 7, 1'b0);
    n = 1;
    while (n < 4) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("abort_ready", bus.ready, 1);
    check("abort_quotient", bus.quotient, 0);
    check("abort_remainder", bus.remainder, 0);
    check("abort_dbz", bus.div_by_zero, 0);
    seen_done = 0;
    repeat (12) begin
      if (bus.done) seen_done = 1;
      @(negedge clk);
    end
    check("abort_no_done", seen_done, 0);
    run_op(100, 9);

    // start held high: back-to-back accepts every 10 cycles.
    bus.a     = 8'hFF;
    bus.b     = 4'hF;
    bus.start = 1'b1;
    t = 0;
    last_t = 0;
    accepts = 0;
    dones = 0;
    while (dones < 3 && t < 100) begin
      if (bus.ready && bus.start) begin
        exp_q.push_back(model(255, 15));
        accepts++;
      end
      @(negedge clk);
      t++;
      if (accepts == 3) bus.start = 1'b0;
      if (bus.done) begin
        if (dones > 0) check("b2b_period", t - last_t, 10);
        last_t = t;
        dones++;
      end
    end
    bus.start = 1'b0;
    check("b2b_dones", dones, 3);

    // Random operands with non-zero divisors.
    for (int i = 0; i < 1500; i++) begin
      run_op(int'($urandom_range(0, 255)), int'($urandom_range(1, 15)));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
